// File: rtl/sample_out_pkg.sv
// Shared encodings and helpers for the resampler output FIFO.
package sample_out_pkg;

   typedef enum logic [1:0] {
      WR_IDLE     = 2'd0,
      WR_ACK      = 2'd1,
      WR_WAIT_LOW = 2'd2
   } wr_state_t;

   typedef enum logic {
      ST_PRIME = 1'b0,
      ST_RUN   = 1'b1
   } st_state_t;

   localparam int UNDERRUN_W = 8;

   function automatic logic [UNDERRUN_W-1:0] sat_inc(input logic [UNDERRUN_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/rate_tick_gen.sv
// Free-running rate divider: one-cycle tick every TICK_DIV clocks, first tick
// in the TICK_DIV-th cycle after reset releases.
module rate_tick_gen #(
   parameter int TICK_DIV = 1024
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == TC);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/sample_out_fifo.sv
// Output FIFO behind the polyphase resampler: req/ack capture on the write
// side, constant-rate release with priming and underrun handling on the read side.
//
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   WR_IDLE      | waiting for req_in; captures when FIFO not full
//   WR_ACK       | ack_in high for this one cycle
//   WR_WAIT_LOW  | waiting for the filter to drop req_in
//   ST_PRIME     | ticks emit zero until level reaches PRIME_LVL
//   ST_RUN       | ticks emit stored samples; empty tick is an underrun
module sample_out_fifo
   import sample_out_pkg::*;
#(
   parameter int DWIDTH    = 16,
   parameter int DEPTH     = 8,
   parameter int DEPTH_LOG = 3,
   parameter int TICK_DIV  = 1024,
   parameter int PRIME_LVL = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         req_in,
   output logic                         ack_in,
   input  logic signed [0:DWIDTH-1]     data_in,
   output logic signed [0:DWIDTH-1]     sample_out,
   output logic                         sample_valid,
   output logic [DEPTH_LOG:0]           level,
   output logic                         running,
   output logic [UNDERRUN_W-1:0]        underrun_cnt
);

   localparam int LW = DEPTH_LOG + 1;
   localparam logic [DEPTH_LOG:0] DEPTH_L = LW'(DEPTH);
   localparam logic [DEPTH_LOG:0] PRIME_L = LW'(PRIME_LVL);

   wr_state_t wr_state, wr_next;
   st_state_t st_state, st_next;

   logic [0:DWIDTH-1]    mem [DEPTH];
   logic [DEPTH_LOG-1:0] wptr, rptr;
   logic                 tick, wr_en, rd_en, underrun;

   rate_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   always_comb begin
      wr_next = wr_state;
      wr_en   = 1'b0;
      case (wr_state)
         WR_IDLE: begin
            if (req_in && (level < DEPTH_L)) begin
               wr_next = WR_ACK;
               wr_en   = 1'b1;
            end
         end
         WR_ACK:      wr_next = WR_WAIT_LOW;
         WR_WAIT_LOW: if (!req_in) wr_next = WR_IDLE;
         default:     wr_next = WR_IDLE;
      endcase
   end

   // Read decisions use the registered level, so a write lands one edge
   // before any tick can consume it.
   always_comb begin
      st_next  = st_state;
      rd_en    = 1'b0;
      underrun = 1'b0;
      case (st_state)
         ST_PRIME: if (level >= PRIME_L) st_next = ST_RUN;
         ST_RUN: begin
            if (tick) begin
               if (level != '0) begin
                  rd_en = 1'b1;
               end else begin
                  underrun = 1'b1;
                  st_next  = ST_PRIME;
               end
            end
         end
         default: st_next = ST_PRIME;
      endcase
   end

   assign ack_in  = (wr_state == WR_ACK);
   assign running = (st_state == ST_RUN);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state     <= WR_IDLE;
         st_state     <= ST_PRIME;
         wptr         <= '0;
         rptr         <= '0;
         level        <= '0;
         sample_out   <= '0;
         sample_valid <= 1'b0;
         underrun_cnt <= '0;
      end else begin
         wr_state     <= wr_next;
         st_state     <= st_next;
         sample_valid <= tick;
         if (wr_en) wptr <= wptr + 1'b1;
         if (rd_en) rptr <= rptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         if (tick) sample_out <= rd_en ? mem[rptr] : '0;
         if (underrun) underrun_cnt <= sat_inc(underrun_cnt);
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wptr] <= data_in;
   end

endmodule

// File: tb/tb_sample_out_fifo.sv
// Directed bench for sample_out_fifo with a queue scoreboard of expected strobe values.
module tb_sample_out_fifo;

   localparam int DWIDTH    = 16;
   localparam int DEPTH     = 8;
   localparam int DEPTH_LOG = 3;
   localparam int TICK_DIV  = 1024;
   localparam int PRIME_LVL = 4;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 req_in = 1'b0;
   logic                 ack_in;
   logic [0:DWIDTH-1]    data_in = '0;
   logic [0:DWIDTH-1]    sample_out;
   logic                 sample_valid;
   logic [DEPTH_LOG:0]   level;
   logic                 running;
   logic [7:0]           underrun_cnt;

   int vectors = 0;
   int miscompares = 0;
   int ack_cnt = 0;
   logic [0:DWIDTH-1] exp_q[$];

   sample_out_fifo #(
      .DWIDTH(DWIDTH), .DEPTH(DEPTH), .DEPTH_LOG(DEPTH_LOG),
      .TICK_DIV(TICK_DIV), .PRIME_LVL(PRIME_LVL)
   ) dut (
      .clk(clk), .rst(rst), .req_in(req_in), .ack_in(ack_in), .data_in(data_in),
      .sample_out(sample_out), .sample_valid(sample_valid), .level(level),
      .running(running), .underrun_cnt(underrun_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (ack_in) ack_cnt++;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_in = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic start_req(input logic [0:DWIDTH-1] d);
      req_in = 1'b1;
      data_in = d;
   endtask

   task automatic wait_ack(output bit got, input int limit);
      got = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (ack_in) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   // Filter keeps req_in for two cycles after seeing ack_in.
   task automatic end_req();
      repeat (2) @(negedge clk);
      req_in = 1'b0;
      @(negedge clk);
   endtask

   task automatic send(input logic [0:DWIDTH-1] d, input int limit);
      bit got;
      exp_q.push_back(d);
      start_req(d);
      wait_ack(got, limit);
      check("ack_wait", got, 1);
      end_req();
   endtask

   task automatic strobe_check(input string tag);
      bit got;
      logic [0:DWIDTH-1] e;
      got = 1'b0;
      for (int i = 0; i < TICK_DIV + 80; i++) begin
         @(negedge clk);
         if (sample_valid) begin
            got = 1'b1;
            break;
         end
      end
      check("strobe_wait", got, 1);
      if (exp_q.size() == 0) begin
         check("sb_depth", exp_q.size(), 1);
      end else begin
         e = exp_q.pop_front();
         check(tag, sample_out, e);
      end
   endtask

   initial begin
      int a0;
      bit got;

      // Reset state
      do_reset();
      check("rst_ack", ack_in, 0);
      check("rst_out", sample_out, 0);
      check("rst_valid", sample_valid, 0);
      check("rst_level", level, 0);
      check("rst_running", running, 0);
      check("rst_underrun", underrun_cnt, 0);

      // Single handshake
      a0 = ack_cnt;
      send(16'h1234, 20);
      check("hs_level", level, 1);
      check("hs_acks", ack_cnt - a0, 1);
      repeat (10) @(negedge clk);
      check("hs_acks_later", ack_cnt - a0, 1);
      check("hs_level_later", level, 1);

      // Priming then underrun
      do_reset();
      exp_q.push_back(16'h0000);
      strobe_check("prime_tick");
      check("prime_running0", running, 0);
      for (int i = 1; i <= 3; i++) send(16'(i), 20);
      check("prime_level3", level, 3);
      check("prime_running3", running, 0);
      exp_q.push_back(16'h0004);
      start_req(16'h0004);
      wait_ack(got, 20);
      check("prime_ack4", got, 1);
      check("prime_level4", level, 4);
      check("prime_run_pre", running, 0);
      @(negedge clk);
      check("prime_run_rise", running, 1);
      @(negedge clk);
      req_in = 1'b0;
      @(negedge clk);
      repeat (4) strobe_check("prime_data");
      exp_q.push_back(16'h0000);
      strobe_check("underrun_out");
      check("underrun_cnt", underrun_cnt, 1);
      check("underrun_running", running, 0);
      check("underrun_level", level, 0);

      // Full FIFO stalls the filter
      do_reset();
      a0 = ack_cnt;
      for (int i = 1; i <= 8; i++) send(16'(i), 20);
      check("full_level", level, 8);
      check("full_acks", ack_cnt - a0, 8);
      start_req(16'h0009);
      repeat (20) @(negedge clk);
      check("full_stall_acks", ack_cnt - a0, 8);
      check("full_stall_ack", ack_in, 0);
      strobe_check("full_drain");
      check("full_after_tick", level, 7);
      wait_ack(got, 5);
      check("full_ack9", got, 1);
      check("full_level_back", level, 8);
      check("full_acks9", ack_cnt - a0, 9);
      end_req();

      // Simultaneous write and tick, then wrap-around streaming
      do_reset();
      for (int i = 1; i <= 4; i++) send(16'(i), 20);
      strobe_check("sim_first");
      check("sim_level3", level, 3);
      repeat (TICK_DIV - 1) @(posedge clk);
      @(negedge clk);
      exp_q.push_back(16'h0005);
      start_req(16'h0005);
      @(negedge clk);
      check("sim_ack", ack_in, 1);
      check("sim_valid", sample_valid, 1);
      check("sim_level", level, 3);
      check("sim_out", sample_out, exp_q.pop_front());
      end_req();
      fork
         begin
            for (int i = 6; i <= 22; i++) send(16'(i), 3000);
         end
         begin
            repeat (20) strobe_check("wrap_out");
         end
      join
      check("wrap_underrun", underrun_cnt, 0);

      // Reset mid-handshake
      do_reset();
      for (int i = 1; i <= 4; i++) send(16'(i), 20);
      start_req(16'h0005);
      wait_ack(got, 20);
      check("mid_ack", got, 1);
      check("mid_level", level, 5);
      rst = 1'b1;
      req_in = 1'b0;
      @(negedge clk);
      check("mid_rst_ack", ack_in, 0);
      check("mid_rst_out", sample_out, 0);
      check("mid_rst_valid", sample_valid, 0);
      check("mid_rst_level", level, 0);
      check("mid_rst_running", running, 0);
      check("mid_rst_underrun", underrun_cnt, 0);
      rst = 1'b0;
      repeat (TICK_DIV - 1) @(negedge clk);
      check("mid_no_early", sample_valid, 0);
      @(negedge clk);
      check("mid_first_strobe", sample_valid, 1);
      check("mid_first_out", sample_out, 0);
      @(negedge clk);
      check("mid_strobe_width", sample_valid, 0);
      check("mid_level_after", level, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sample_out_fifo.md
# sample_out_fifo

Output stage directly downstream of the polyphase resampling filter. It accepts resampled 16-bit signed samples over the filter's req/ack output handshake and buffers them in a small circular FIFO. It releases them at a fixed sample rate derived from `clk` by a programmable divider, which decouples the filter's bursty output timing from the constant-rate DAC/serializer interface. Underruns are counted and handled deterministically.

## Interface
Parameters:
- `DWIDTH`, 16: sample width.
- `DEPTH`, 8: FIFO entries; must be a power of 2.
- `DEPTH_LOG`, 3: log2(`DEPTH`).
- `TICK_DIV`, 1024: `clk` cycles per output sample; must be ≥ 4.
- `PRIME_LVL`, 4: fill level required before streaming starts; must satisfy 1 ≤ `PRIME_LVL` ≤ `DEPTH`.

Ports:
- `clk`  in  1: clock. Reset `rst` is synchronous and active-high; clock is `clk`.
- `rst`  in  1: synchronous active-high reset.
- `req_in`  in  1: the filter has a valid sample on `data_in`. The filter holds it until it sees `ack_in`.
- `ack_in`  out  1: sample accepted; one-cycle pulse.
- `data_in`  in  `[0:DWIDTH-1]` signed: sample from the filter; bit 0 is the MSB.
- `sample_out`  out  `[0:DWIDTH-1]` signed: registered output sample.
- `sample_valid`  out  1: one-cycle strobe, once every `TICK_DIV` cycles.
- `level`  out  `DEPTH_LOG+1`: current FIFO occupancy, 0..`DEPTH`.
- `running`  out  1: 1 in RUN, 0 in PRIME.
- `underrun_cnt`  out  8: saturating count of underruns.

## Operation
- **Write side (FSM):**
  - IDLE → ACK when `req_in`=1 and `level`<`DEPTH`. At that edge the block writes `data_in` to `mem[wptr]`, increments `wptr` modulo `DEPTH`, and sets `ack_in`=1.
  - ACK → WAIT_LOW unconditionally; `ack_in` returns to 0.
  - WAIT_LOW → IDLE when `req_in`=0. This guarantees exactly one capture per filter request, because the filter holds `req_in` for 2 cycles after seeing `ack_in`.
- **Full:** while `level`=`DEPTH`, the block stays in IDLE with `ack_in`=0. The filter stalls; no data is dropped.
- **Tick generator:** free-running counter 0..`TICK_DIV`-1. `tick`=1 when the counter equals `TICK_DIV`-1, then the counter wraps to 0.
- **Read side (stream FSM):**
  - PRIME: on each tick, `sample_out`←0 and `sample_valid` pulses. PRIME → RUN when `level`≥`PRIME_LVL`, evaluated at any edge.
  - RUN: on each tick with `level`>0, `sample_out`←`mem[rptr]` and `rptr` increments.
  - RUN, tick with `level`=0 (underrun): `sample_out`←0, `underrun_cnt` increments and saturates at 255, and the FSM returns to PRIME.
- **Simultaneous write and read in the same edge:** `level` is unchanged and both pointers advance.
- **Wrap-around:** pointers are `DEPTH_LOG` bits wide and wrap naturally. `level` is tracked as a separate counter.
- **Reset:** applies at any time, including mid-handshake.
  - Reset values: `ack_in`=0, `sample_out`=0, `sample_valid`=0, `level`=0, `running`=0, `underrun_cnt`=0.
  - Pointers and tick counter clear to 0; both FSMs return to IDLE/PRIME.
  - FIFO contents are not cleared.

## Timing
- **Accept latency:** if `req_in` rises before edge n while in IDLE and not full, then `ack_in`=1 after edge n and `level` is updated after edge n.
- **Next accept:** no earlier than 2 cycles after `req_in` falls.
- **Output strobes:** `sample_valid` is high for exactly 1 cycle, every `TICK_DIV` cycles. The first strobe comes `TICK_DIV` cycles after reset deasserts. `sample_out` is stable between strobes.
- **Write-to-output latency:** a write is visible to a tick at the next edge. A sample written at edge n can be output by a tick at edge n+1 or later.
- **Start of streaming:** `running` rises 1 cycle after `level` reaches `PRIME_LVL`.

## Structure
- Package `sample_out_pkg` holds:
  - write FSM state encoding (IDLE, ACK, WAIT_LOW);
  - stream FSM state encoding (PRIME, RUN);
  - the 8-bit underrun counter width constant.
- One sub-module, `rate_tick_gen` (parameter `TICK_DIV`, ports `clk`, `rst`, `tick`), which is reusable for the input-side rate.
- FIFO storage is a plain register array inside `sample_out_fifo`.

## Test plan
1. **Single handshake:** reset, then hold `req_in`=1 with `data_in`=16'h1234 until `ack_in` is seen, then drop it 2 cycles later. Required: exactly one `ack_in` pulse, `level`=1, no second capture.
2. **Priming:** `PRIME_LVL`=4, write 16'h0001..16'h0004 quickly. Required: ticks before `running`=1 output 0. The next 4 strobes output 1, 2, 3, 4 in order.
3. **Full:** write 9 samples with no ticks, using `TICK_DIV`=1024. Required: 8 acks, `level`=8, the 9th `req_in` stays unacknowledged. After one tick it is accepted and `level` returns to 8.
4. **Underrun:** prime with 4 samples, then stop writing. Required: 4 valid outputs, the 5th strobe outputs 0, `underrun_cnt`=1, `running`=0.
5. **Simultaneous access and wrap:** with `level`=3, a write and a tick land on the same edge. Required: `level` stays 3. Run 20 samples through the FIFO; they come out in order across pointer wrap.
6. **Reset mid-operation:** assert `rst` while `ack_in`=1 and `level`=5. Required: all outputs at reset values on the next cycle, and the first strobe comes `TICK_DIV` cycles after `rst` deasserts.
